// File: rtl/dmem_arbiter.sv
`default_nettype none
// ======================================================================
// dmem_arbiter : round-robin two-requester access sequencer for data_memory
// Revision 1.0
// ======================================================================
module dmem_arbiter #(
   parameter int MEM_BYTES = 256,
   parameter int AW        = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          r0_valid,
   output logic          r0_ready,
   input  logic [AW-1:0] r0_addr,
   input  logic          r0_we,
   input  logic [2:0]    r0_ctrl,
   input  logic [31:0]   r0_wdata,
   output logic          r0_rsp_valid,
   input  logic          r0_rsp_ready,
   output logic [31:0]   r0_rsp_data,
   output logic          r0_rsp_err,
   input  logic          r1_valid,
   output logic          r1_ready,
   input  logic [AW-1:0] r1_addr,
   input  logic          r1_we,
   input  logic [2:0]    r1_ctrl,
   input  logic [31:0]   r1_wdata,
   output logic          r1_rsp_valid,
   input  logic          r1_rsp_ready,
   output logic [31:0]   r1_rsp_data,
   output logic          r1_rsp_err,
   output logic [31:0]   mem_address,
   output logic [31:0]   mem_write_data,
   output logic          mem_write_enable,
   output logic [2:0]    mem_dm_ctrl,
   input  logic [31:0]   mem_read_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [AW-1:0] c_mem_limit = AW'(MEM_BYTES);

   state_t        state_q, state_d;
   logic          last_grant_q;
   logic          id_q;
   logic          we_q;
   logic          err_q;
   logic [2:0]    ctrl_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rsp_data_q;
   logic          rsp_err_q;

   logic          gnt_valid;
   logic          gnt_id;
   logic          accept;
   logic [AW-1:0] sel_addr;
   logic          sel_we;
   logic [2:0]    sel_ctrl;
   logic [31:0]   sel_wdata;
   logic          sel_err;

   // On a tie the requester that did not win last time is chosen.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = 1'b0;
      if (r0_valid && r1_valid) begin
         gnt_valid = 1'b1;
         gnt_id    = ~last_grant_q;
      end else if (r0_valid) begin
         gnt_valid = 1'b1;
      end else if (r1_valid) begin
         gnt_valid = 1'b1;
         gnt_id    = 1'b1;
      end
   end

   assign accept   = (state_q == IDLE) && gnt_valid && rst_n;
   assign r0_ready = accept && !gnt_id;
   assign r1_ready = accept && gnt_id;

   assign sel_addr  = gnt_id ? r1_addr  : r0_addr;
   assign sel_we    = gnt_id ? r1_we    : r0_we;
   assign sel_ctrl  = gnt_id ? r1_ctrl  : r0_ctrl;
   assign sel_wdata = gnt_id ? r1_wdata : r0_wdata;

   always_comb begin
      sel_err = 1'b0;
      case (sel_ctrl)
         3'b000:  sel_err = 1'b0;
         3'b001:  sel_err = sel_addr[0];
         3'b010:  sel_err = |sel_addr[1:0];
         3'b100:  sel_err = sel_we;
         3'b101:  sel_err = sel_we || sel_addr[0];
         default: sel_err = 1'b1;
      endcase
      if (sel_addr >= c_mem_limit) begin
         sel_err = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    if (id_q ? r1_rsp_ready : r0_rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The latched request doubles as the memory bus, so it holds outside ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         ctrl_q       <= 3'b010;
         addr_q       <= '0;
         wdata_q      <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         if (accept) begin
            last_grant_q <= gnt_id;
            id_q         <= gnt_id;
            we_q         <= sel_we;
            err_q        <= sel_err;
            ctrl_q       <= sel_ctrl;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
         end
         if (state_q == ACCESS) begin
            rsp_data_q <= (we_q || err_q) ? 32'h0 : mem_read_data;
            rsp_err_q  <= err_q;
         end
      end
   end

   assign mem_address      = 32'(addr_q);
   assign mem_write_data   = wdata_q;
   assign mem_dm_ctrl      = ctrl_q;
   assign mem_write_enable = (state_q == ACCESS) && we_q && !err_q;

   assign r0_rsp_valid = (state_q == RESP) && !id_q;
   assign r1_rsp_valid = (state_q == RESP) && id_q;
   assign r0_rsp_data  = id_q ? 32'h0 : rsp_data_q;
   assign r1_rsp_data  = id_q ? rsp_data_q : 32'h0;
   assign r0_rsp_err   = !id_q && rsp_err_q;
   assign r1_rsp_err   = id_q && rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter : directed vector table plus hand sequences, with a
// little-endian byte-array model of data_memory (byte i preloaded with i).
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        r0_valid, r0_ready, r0_we, r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
   logic        r1_valid, r1_ready, r1_we, r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
   logic [31:0] r0_addr, r0_wdata, r0_rsp_data, r1_addr, r1_wdata, r1_rsp_data;
   logic [2:0]  r0_ctrl, r1_ctrl;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_write_enable;
   logic [2:0]  mem_dm_ctrl;

   int n_pass  = 0;
   int n_total = 0;

   dmem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_we(r0_we),
      .r0_ctrl(r0_ctrl), .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid),
      .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_we(r1_we),
      .r1_ctrl(r1_ctrl), .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid),
      .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write_enable(mem_write_enable), .mem_dm_ctrl(mem_dm_ctrl),
      .mem_read_data(mem_read_data)
   );

   // data_memory model
   logic [7:0] mem [256];
   logic [7:0] a0, a1, a2, a3;
   assign a0 = mem_address[7:0];
   assign a1 = a0 + 8'd1;
   assign a2 = a0 + 8'd2;
   assign a3 = a0 + 8'd3;

   always_comb begin
      mem_read_data = 32'h0;
      case (mem_dm_ctrl)
         3'b000:  mem_read_data = {{24{mem[a0][7]}}, mem[a0]};
         3'b001:  mem_read_data = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
         3'b010:  mem_read_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
         3'b100:  mem_read_data = {24'h0, mem[a0]};
         3'b101:  mem_read_data = {16'h0, mem[a1], mem[a0]};
         default: mem_read_data = 32'h0;
      endcase
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      forever begin
         @(posedge clk);
         if (mem_write_enable) begin
            mem[a0] <= mem_write_data[7:0];
            if (mem_dm_ctrl[1:0] != 2'b00) mem[a1] <= mem_write_data[15:8];
            if (mem_dm_ctrl == 3'b010) begin
               mem[a2] <= mem_write_data[23:16];
               mem[a3] <= mem_write_data[31:24];
            end
         end
      end
   end

   typedef struct {
      logic        we;
      logic [2:0]  ctrl;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_err);
      vec_t v;
      v.we = we; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata;
      v.exp_data = exp_data; v.exp_err = exp_err;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " ctl"}, {22'h0, r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid,
                          r0_rsp_err, r1_rsp_err, mem_write_enable, mem_dm_ctrl},
          32'h0000_0002);
      chk({tag, " rsp_data"}, r0_rsp_data | r1_rsp_data, 32'h0);
      chk({tag, " mem_address"}, mem_address, 32'h0);
      chk({tag, " mem_write_data"}, mem_write_data, 32'h0);
   endtask

   // Called and returns at 1 time unit after a rising edge, arbiter in IDLE.
   task automatic txn(input logic req, input logic we, input logic [2:0] ctrl,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] data, output logic err, output int lat,
                      output int wecnt, output logic ok);
      int guard;
      ok = 1'b0; data = 32'h0; err = 1'b0; lat = 0; wecnt = 0;
      if (!req) begin
         r0_valid = 1'b1; r0_we = we; r0_ctrl = ctrl; r0_addr = addr; r0_wdata = wdata;
         r0_rsp_ready = 1'b1;
      end else begin
         r1_valid = 1'b1; r1_we = we; r1_ctrl = ctrl; r1_addr = addr; r1_wdata = wdata;
         r1_rsp_ready = 1'b1;
      end
      #1;
      guard = 0;
      while (!(req ? r1_ready : r0_ready) && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 20) begin
         n_total++;
         $display("FAIL accept timeout: requester %0d never got ready", req);
         r0_valid = 1'b0; r1_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      r0_valid = 1'b0; r1_valid = 1'b0;
      lat = 1;
      guard = 0;
      while (!(req ? r1_rsp_valid : r0_rsp_valid) && guard < 20) begin
         if (mem_write_enable) wecnt++;
         @(posedge clk); #1; lat++; guard++;
      end
      if (guard >= 20) begin
         n_total++;
         $display("FAIL response timeout: requester %0d got no rsp_valid", req);
         return;
      end
      data = req ? r1_rsp_data : r0_rsp_data;
      err  = req ? r1_rsp_err  : r0_rsp_err;
      ok   = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        e, ok;
      int          lat, wec, guard;

      rst_n = 1'b0;
      r0_valid = 0; r0_we = 0; r0_ctrl = 3'b010; r0_addr = 0; r0_wdata = 0; r0_rsp_ready = 1;
      r1_valid = 0; r1_we = 0; r1_ctrl = 3'b010; r1_addr = 0; r1_wdata = 0; r1_rsp_ready = 1;

      //        we  ctrl    addr        wdata         exp_data      err
      add(1'b1, 3'b010, 32'h020, 32'hDEADBEEF, 32'h00000000, 1'b0);
      add(1'b0, 3'b010, 32'h020, 32'h0,        32'hDEADBEEF, 1'b0);
      add(1'b0, 3'b000, 32'h023, 32'h0,        32'hFFFFFFDE, 1'b0);
      add(1'b0, 3'b100, 32'h023, 32'h0,        32'h000000DE, 1'b0);
      add(1'b0, 3'b001, 32'h020, 32'h0,        32'hFFFFBEEF, 1'b0);
      add(1'b0, 3'b101, 32'h022, 32'h0,        32'h0000DEAD, 1'b0);
      add(1'b0, 3'b010, 32'h022, 32'h0,        32'h00000000, 1'b1);
      add(1'b1, 3'b001, 32'h041, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      add(1'b1, 3'b010, 32'h100, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      add(1'b1, 3'b100, 32'h044, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      add(1'b0, 3'b111, 32'h044, 32'h0,        32'h00000000, 1'b1);
      add(1'b1, 3'b011, 32'h044, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      add(1'b1, 3'b101, 32'h044, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      add(1'b0, 3'b010, 32'h044, 32'h0,        32'h47464544, 1'b0);
      add(1'b0, 3'b010, 32'h0FC, 32'h0,        32'hFFFEFDFC, 1'b0);
      add(1'b0, 3'b000, 32'h0FF, 32'h0,        32'hFFFFFFFF, 1'b0);
      add(1'b0, 3'b100, 32'h100, 32'h0,        32'h00000000, 1'b1);
      add(1'b1, 3'b000, 32'h046, 32'h123456AA, 32'h00000000, 1'b0);
      add(1'b0, 3'b010, 32'h044, 32'h0,        32'h47AA4544, 1'b0);
      add(1'b0, 3'b001, 32'h07E, 32'h0,        32'h00007F7E, 1'b0);
      add(1'b1, 3'b001, 32'h060, 32'h00008001, 32'h00000000, 1'b0);
      add(1'b0, 3'b001, 32'h060, 32'h0,        32'hFFFF8001, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         txn(1'b0, vecs[i].we, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, d, e, lat, wec, ok);
         if (ok) begin
            chk($sformatf("vec%0d data", i), d, vecs[i].exp_data);
            chk($sformatf("vec%0d err", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
            chk($sformatf("vec%0d latency", i), lat, 2);
            chk($sformatf("vec%0d write pulses", i), wec,
                (vecs[i].we && !vecs[i].exp_err) ? 1 : 0);
            chk($sformatf("vec%0d rsp_valid cleared", i), {31'h0, r0_rsp_valid}, 32'h0);
         end
      end

      // Round-robin from a fresh reset with both requesters held valid.
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      r0_valid = 1; r0_we = 0; r0_ctrl = 3'b010; r0_addr = 32'h44;
      r1_valid = 1; r1_we = 0; r1_ctrl = 3'b010; r1_addr = 32'h44;
      for (int k = 0; k < 4; k++) begin
         #1;
         guard = 0;
         while (!(r0_ready || r1_ready) && guard < 10) begin
            @(posedge clk); #1; guard++;
         end
         chk($sformatf("grant %0d {r0,r1}", k), {30'h0, r0_ready, r1_ready},
             (k % 2 == 0) ? 32'h2 : 32'h1);
         @(posedge clk); #1;
      end
      r0_valid = 0; r1_valid = 0;
      repeat (3) @(posedge clk);
      #1;

      // Lone r1 request is granted in the first IDLE cycle.
      r1_valid = 1; r1_we = 0; r1_ctrl = 3'b010; r1_addr = 32'h20;
      #1;
      chk("lone r1 {r0,r1}_ready", {30'h0, r0_ready, r1_ready}, 32'h1);
      txn(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, d, e, lat, wec, ok);
      if (ok) chk("lone r1 data", d, 32'hDEADBEEF);

      // Response backpressure on r1 while r0 waits.
      r1_valid = 1; r1_we = 0; r1_ctrl = 3'b101; r1_addr = 32'h22; r1_rsp_ready = 0;
      #1;
      chk("bp r1_ready", {31'h0, r1_ready}, 32'h1);
      @(posedge clk); #1;
      r1_valid = 0;
      r0_valid = 1; r0_we = 0; r0_ctrl = 3'b010; r0_addr = 32'h44; r0_rsp_ready = 1;
      #1;
      chk("bp r0_ready in ACCESS", {31'h0, r0_ready}, 32'h0);
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp cycle%0d {r1v,r0rdy,r0v,r1err}", k),
             {28'h0, r1_rsp_valid, r0_ready, r0_rsp_valid, r1_rsp_err}, 32'h8);
         chk($sformatf("bp cycle%0d r1_rsp_data", k), r1_rsp_data, 32'h0000DEAD);
         @(posedge clk); #1;
      end
      r1_rsp_ready = 1;
      #1;
      chk("bp r0_ready while RESP", {31'h0, r0_ready}, 32'h0);
      @(posedge clk); #1;
      chk("bp after release {r0rdy,r1rdy,r1v}", {29'h0, r0_ready, r1_ready, r1_rsp_valid}, 32'h4);
      @(posedge clk); #1;
      r0_valid = 0;
      @(posedge clk); #1;
      chk("bp r0 rsp_valid", {31'h0, r0_rsp_valid}, 32'h1);
      chk("bp r0 rsp_data", r0_rsp_data, 32'h47AA4544);
      @(posedge clk); #1;

      // Reset during the ACCESS cycle of a store.
      r0_valid = 1; r0_we = 1; r0_ctrl = 3'b010; r0_addr = 32'h30; r0_wdata = 32'h11111111;
      #1;
      guard = 0;
      while (!r0_ready && guard < 10) begin
         @(posedge clk); #1; guard++;
      end
      chk("midreset r0_ready", {31'h0, r0_ready}, 32'h1);
      @(posedge clk); #1;
      r0_valid = 0;
      chk("midreset write_enable in ACCESS", {31'h0, mem_write_enable}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk_reset("midreset");
      repeat (2) @(posedge clk);
      #1;
      chk("midreset held rsp_valid", {30'h0, r0_rsp_valid, r1_rsp_valid}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midreset after release rsp_valid", {30'h0, r0_rsp_valid, r1_rsp_valid}, 32'h0);
      txn(1'b0, 1'b0, 3'b010, 32'h30, 32'h0, d, e, lat, wec, ok);
      if (ok) chk("midreset LW 0x30", d, 32'h33323130);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
